tt_um_cybernerd_manchester: RTL and testbench
=============================================

TT_UM_CYBERNERD_MANCHESTER -- requirements
Module: tt_um_cybernerd_manchester

Interface
REQ-001 Parameter: HALF_BIT, default 8, clock cycles per Manchester half-bit; legal values are even numbers of 4 or more.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-high (asserted when 1), despite the name.
REQ-004 Port: ena  input  1  design-selected flag; tx_start is ignored while ena=0; all other logic runs regardless.
REQ-005 Port: ui_in  input  8  transmit byte, latched at tx start.
REQ-006 Port: uio_in  input  8  bit0=tx_start (level, sampled), bit1=rx_in (serial Manchester input); bits 7:2 unused.
REQ-007 Port: uio_out  output  8  bits 1:0=0, bit2=tx_out, bit3=tx_busy, bit4=rx_valid, bit5=rx_error, bits 7:6=0.
REQ-008 Port: uio_oe  output  8  constant 8'b1111_1100.
REQ-009 Port: uo_out  output  8  last correctly received byte (rx_data).

Function
REQ-010 Coding is IEEE 802.3: bit 1 = low half then high half; bit 0 = high half then low half; each half lasts HALF_BIT cycles.
REQ-011 Frame = one start bit (value 1), then 8 data bits MSB first; the idle line is low.
REQ-012 Encoder: when idle, ena=1 and tx_start=1 at a rising edge, ui_in is latched and tx_busy=1 from the next cycle.
REQ-013 The encoder drives the frame on tx_out starting in that same next cycle; the frame lasts 18*HALF_BIT cycles.
REQ-014 After the frame, tx_out=0 and tx_busy=0; tx_start held high restarts immediately, with no gap cycle required.
REQ-015 tx_start is ignored while tx_busy=1; the latched byte is not disturbed.
REQ-016 Decoder: rx_in passes through a 2-flop synchronizer; all decoder timing is relative to the synchronized signal.
REQ-017 In idle, a synchronized rising edge is taken as the start-bit mid-transition; rx_valid and rx_error clear on that cycle.
REQ-018 Let E = the edge-detect cycle; for data bit k=0..7, sample A at E+HALF_BIT*(2k+1)+HALF_BIT/2 and sample B at E+HALF_BIT*(2k+2)+HALF_BIT/2.
REQ-019 The decoded bit = B; A==B is a coding error.
REQ-020 On a coding error, rx_error=1, the decoder returns to idle, and rx_data is unchanged.
REQ-021 After bit 7 is decoded without error, rx_data updates and rx_valid=1 on the same cycle.
REQ-022 rx_valid and rx_error hold until the next start detect or reset.
REQ-023 After completion or error, the decoder waits for the line to be low for at least one synchronized cycle before re-arming edge detect.
REQ-024 Encoder and decoder are independent and may operate simultaneously (full duplex).

Reset
REQ-025 While rst_n=1, all outputs are asynchronously forced: tx_out=0, tx_busy=0, rx_valid=0, rx_error=0, uo_out=8'h00.
REQ-026 While rst_n=1, both FSMs are forced to IDLE and the synchronizer flops to 0.
REQ-027 Reset asserted mid-frame aborts both directions; no partial byte reaches uo_out.
REQ-028 After deassertion, the first tx_start is honoured on the first rising edge.

Structure
REQ-029 Package manchester_pkg shall hold the HALF_BIT default, frame length 9, and the TX/RX state enums (IDLE, SEND / IDLE, SAMPLE, WAIT_LOW).
REQ-030 One sub-module, manchester_decoder (synchronizer, edge detect, sampling FSM), instantiated once; the encoder lives inline in the top.

Verification
REQ-031 HALF_BIT=8, ui_in=8'hA5, pulse tx_start for 1 cycle -> tx_busy high for exactly 144 cycles; tx_out=0 for 8 cycles then 1 for 8 (start bit), then data bit 7 (1) = low 8 then high 8.
REQ-032 Loopback (tx_out wired to rx_in), send 8'h3C -> uo_out=8'h3C, rx_valid=1, rx_error=0 within 150 cycles of tx_start.
REQ-033 After a rising edge on rx_in, hold rx_in=1 constant -> rx_error=1 after bit 0, rx_valid=0, uo_out keeps its previous value.
REQ-034 tx_start re-pulsed at cycle 50 of a frame with ui_in changed to 8'hFF -> original byte transmits unchanged; frame length stays 144 cycles.
REQ-035 Assert rst_n=1 at cycle 70 of a loopback frame -> all outputs 0 immediately; a following 8'h81 loopback frame decodes correctly.
REQ-036 tx_start=1 with ena=0 -> tx_busy stays 0 and tx_out stays 0.

Source files
------------

// File: rtl/manchester_pkg.sv
// Shared constants and state types for the Manchester encoder/decoder pair.
package manchester_pkg;

  localparam int HALF_BIT_DEF = 8;
  localparam int FRAME_BITS   = 9;
  localparam int FRAME_HALVES = 2 * FRAME_BITS;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_SAMPLE, RX_WAIT_LOW} rx_state_t;

  function automatic int cnt_w(input int half_bit);
    return (half_bit < 2) ? 1 : $clog2(half_bit);
  endfunction

endpackage

// File: rtl/manchester_decoder.sv
// Manchester receiver: 2-flop synchronizer, start-edge detect and a mid-half
// sampling FSM that checks both halves of each data bit.
module manchester_decoder
  import manchester_pkg::*;
#(
  parameter int HALF_BIT = HALF_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int            CW        = cnt_w(HALF_BIT);
  localparam logic [CW-1:0] PH_MID    = CW'(HALF_BIT / 2);
  localparam logic [CW-1:0] PH_LAST   = CW'(HALF_BIT - 1);
  localparam logic [4:0]    HALF_LAST = 5'(FRAME_HALVES - 2);

  rx_state_t     state, state_nxt;
  logic          sync_p0, sync_p1, prev_p2;
  logic [CW-1:0] ph;
  logic [4:0]    hidx;
  logic          a_bit;
  logic [6:0]    shift;
  logic          edge_det, at_mid, samp_a, samp_b, bit_err, last_bit;

  // Stage p0/p1: synchronizer; stage p2: previous synchronized level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= rx_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RX_IDLE:     if (edge_det) state_nxt = RX_SAMPLE;
      RX_SAMPLE:   if (bit_err || last_bit) state_nxt = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!sync_p1) state_nxt = RX_IDLE;
      default:     state_nxt = RX_IDLE;
    endcase
  end

  // Odd half index = first half of a data bit (A), even = second half (B)
  always_comb begin
    edge_det = (state == RX_IDLE) && sync_p1 && !prev_p2;
    at_mid   = (ph == PH_MID) && (hidx != 5'd0);
    samp_a   = (state == RX_SAMPLE) && at_mid && hidx[0];
    samp_b   = (state == RX_SAMPLE) && at_mid && !hidx[0];
    bit_err  = samp_b && (sync_p1 == a_bit);
    last_bit = samp_b && (hidx == HALF_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph       <= '0;
      hidx     <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else if (edge_det) begin
      ph       <= CW'(1);
      hidx     <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else if (state == RX_SAMPLE) begin
      if (ph == PH_LAST) begin
        ph   <= '0;
        hidx <= hidx + 5'd1;
      end else begin
        ph <= ph + CW'(1);
      end
      if (bit_err) begin
        rx_error <= 1'b1;
      end else if (last_bit) begin
        rx_data  <= {shift, sync_p1};
        rx_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (samp_a) a_bit <= sync_p1;
    if (samp_b) shift <= {shift[5:0], sync_p1};
  end

endmodule

// File: rtl/tt_um_cybernerd_manchester.sv
// Full-duplex IEEE 802.3 Manchester transceiver: inline frame encoder plus
// the manchester_decoder receiver, packed onto the Tiny Tapeout pin map.
module tt_um_cybernerd_manchester
  import manchester_pkg::*;
#(
  parameter int HALF_BIT = HALF_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int            CW       = cnt_w(HALF_BIT);
  localparam logic [CW-1:0] PH_LAST  = CW'(HALF_BIT - 1);
  localparam logic [4:0]    HALF_END = 5'(FRAME_HALVES - 1);

  tx_state_t     tx_state, tx_state_nxt;
  logic [CW-1:0] tx_ph;
  logic [4:0]    tx_half;
  logic [8:0]    tx_shift;
  logic          tx_start_ok, tx_half_end, tx_frame_end, tx_load;
  logic          tx_out, tx_busy;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_error;
  logic          unused_uio;

  assign unused_uio = &{1'b0, uio_in[7:2]};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  // A start held across the last frame cycle reloads without a gap
  always_comb begin
    tx_start_ok  = ena && uio_in[0];
    tx_half_end  = (tx_state == TX_SEND) && (tx_ph == PH_LAST);
    tx_frame_end = tx_half_end && (tx_half == HALF_END);
    tx_load      = tx_start_ok && ((tx_state == TX_IDLE) || tx_frame_end);
    tx_state_nxt = tx_state;
    unique case (tx_state)
      TX_IDLE: if (tx_start_ok) tx_state_nxt = TX_SEND;
      TX_SEND: if (tx_frame_end && !tx_start_ok) tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_busy = (tx_state == TX_SEND);
    tx_out  = tx_busy && (tx_half[0] ? tx_shift[8] : !tx_shift[8]);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_ph   <= '0;
      tx_half <= '0;
    end else if (tx_load) begin
      tx_ph   <= '0;
      tx_half <= '0;
    end else if (tx_half_end) begin
      tx_ph   <= '0;
      tx_half <= tx_half + 5'd1;
    end else if (tx_state == TX_SEND) begin
      tx_ph <= tx_ph + CW'(1);
    end
  end

  // Start bit sits in bit 8; shift once per completed bit (after odd half)
  always_ff @(posedge clk) begin
    if (tx_load)                        tx_shift <= {1'b1, ui_in};
    else if (tx_half_end && tx_half[0]) tx_shift <= {tx_shift[7:0], 1'b0};
  end

  manchester_decoder #(
    .HALF_BIT(HALF_BIT)
  ) u_decoder (
    .clk     (clk),
    .rst     (rst_n),
    .rx_in   (uio_in[1]),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_error(rx_error)
  );

  assign uio_out = {2'b00, rx_error, rx_valid, tx_busy, tx_out, 2'b00};
  assign uio_oe  = 8'b1111_1100;
  assign uo_out  = rx_data;

endmodule

// File: tb/tb_tt_um_cybernerd_manchester.sv
// Self-checking bench: per-cycle comparison against a behavioural Manchester
// model, directed frame scenarios, and randomized loopback / line-noise traffic.
`timescale 1ns/1ps
module tb_tt_um_cybernerd_manchester;

  localparam int HB        = 8;
  localparam int FRAME_CYC = 18 * HB;

  logic       clk = 1'b0;
  logic       rst_n, ena, tx_start, rx_drv, loopback;
  logic [7:0] ui_in, uio_in, uio_out, uio_oe, uo_out;
  int         n_tests = 0;
  int         n_fail  = 0;

  assign uio_in = {6'b0, (loopback ? uio_out[2] : rx_drv), tx_start};

  tt_um_cybernerd_manchester #(.HALF_BIT(HB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .uo_out (uo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level t cycles into a frame carrying byte b (start bit 1, MSB first)
  function automatic logic manch_level(input logic [7:0] b, input int t);
    int   j;
    logic v;
    j = t / (2 * HB);
    v = (j == 0) ? 1'b1 : b[8 - j];
    return ((t / HB) % 2 == 1) ? v : ~v;
  endfunction

  logic       m_tx_busy;
  logic [7:0] m_tx_byte;
  int         m_tx_t;
  int         m_rx_mode;
  int         m_rx_off;
  logic       m_d1, m_d2, m_prev, m_valid, m_err;
  logic [7:0] m_a, m_acc, m_rx_data;

  always @(negedge clk) begin
    logic       s;
    int         h;
    logic [7:0] exp_uio;
    if (rst_n)
      exp_uio = 8'h00;
    else
      exp_uio = {2'b00, m_err, m_valid, m_tx_busy,
                 (m_tx_busy ? manch_level(m_tx_byte, m_tx_t) : 1'b0), 2'b00};
    check("uio_out", {24'b0, uio_out}, {24'b0, exp_uio});
    check("uo_out", {24'b0, uo_out}, {24'b0, (rst_n ? 8'h00 : m_rx_data)});
    check("uio_oe", {24'b0, uio_oe}, 32'hFC);
    if (rst_n) begin
      m_tx_busy = 1'b0; m_tx_byte = 8'h00; m_tx_t = 0;
      m_rx_mode = 0; m_rx_off = 0; m_d1 = 1'b0; m_d2 = 1'b0; m_prev = 1'b0;
      m_valid = 1'b0; m_err = 1'b0; m_a = 8'h00; m_acc = 8'h00; m_rx_data = 8'h00;
    end else begin
      if (m_tx_busy) begin
        m_tx_t++;
        if (m_tx_t == FRAME_CYC) m_tx_busy = 1'b0;
      end
      if (!m_tx_busy && ena && tx_start) begin
        m_tx_busy = 1'b1; m_tx_byte = ui_in; m_tx_t = 0;
      end
      s = m_d2;
      case (m_rx_mode)
        0: if (s && !m_prev) begin
             m_rx_mode = 1; m_rx_off = 0; m_valid = 1'b0; m_err = 1'b0;
           end
        1: begin
          m_rx_off++;
          if (m_rx_off >= HB && (m_rx_off - HB / 2) % HB == 0) begin
            h = (m_rx_off - HB / 2) / HB;
            if (h % 2 == 1) begin
              m_a[(h - 1) / 2] = s;
            end else if (s == m_a[h / 2 - 1]) begin
              m_err = 1'b1; m_rx_mode = 2;
            end else begin
              m_acc[7 - (h / 2 - 1)] = s;
              if (h == 16) begin
                m_rx_data = m_acc; m_valid = 1'b1; m_rx_mode = 2;
              end
            end
          end
        end
        default: if (!s) m_rx_mode = 0;
      endcase
      m_prev = s;
      m_d2   = m_d1;
      m_d1   = uio_in[1];
    end
  end

  // Observe one transmit frame from its first busy cycle; optionally re-pulse start
  task automatic watch_frame(input int repulse_at, output int busy_cnt,
                             output logic [31:0] head, output logic [8:0] fbits);
    busy_cnt = 0; head = '0; fbits = '0;
    #1;
    for (int i = 0; i < FRAME_CYC + 40; i++) begin
      if (uio_out[3]) begin
        if (busy_cnt < 32) head[31 - busy_cnt] = uio_out[2];
        if (busy_cnt % (2 * HB) == HB + HB / 2) fbits[8 - busy_cnt / (2 * HB)] = uio_out[2];
        busy_cnt++;
      end
      if (i == repulse_at) begin ui_in = 8'hFF; tx_start = 1'b1; end
      if (i == repulse_at + 1) tx_start = 1'b0;
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_valid(output int waited);
    waited = 1;
    while (!uio_out[4] && waited < 150) begin
      @(posedge clk); #1;
      waited++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          busy_cnt, waited, valid_seen;
    logic [31:0] head;
    logic [8:0]  fbits;
    rst_n = 1'b1; ena = 1'b1; tx_start = 1'b0; rx_drv = 1'b0; loopback = 1'b0; ui_in = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("reset_uo_out", {24'b0, uo_out}, 32'h00);
    check("reset_uio_out", {24'b0, uio_out}, 32'h00);
    check("reset_uio_oe", {24'b0, uio_oe}, 32'hFC);

    // Start requested in the very cycle reset is released
    @(posedge clk); #1 rst_n = 1'b0; ui_in = 8'hA5; tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    watch_frame(-1, busy_cnt, head, fbits);
    check("a5_busy_len", busy_cnt, 144);
    check("a5_head_wave", head, 32'h00FF00FF);
    check("a5_frame_bits", {23'b0, fbits}, {23'b0, 9'h1A5});

    @(posedge clk); #1 ena = 1'b0; tx_start = 1'b1; ui_in = 8'h3C;
    repeat (20) @(posedge clk);
    #2;
    check("ena0_busy", {31'b0, uio_out[3]}, 32'h0);
    check("ena0_tx_out", {31'b0, uio_out[2]}, 32'h0);
    @(posedge clk); #1 tx_start = 1'b0; ena = 1'b1;

    @(posedge clk); #1 loopback = 1'b1; ui_in = 8'h3C; tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    wait_valid(waited);
    check("lb3c_in_time", 32'(waited < 150), 32'h1);
    check("lb3c_valid", {31'b0, uio_out[4]}, 32'h1);
    check("lb3c_error", {31'b0, uio_out[5]}, 32'h0);
    check("lb3c_data", {24'b0, uo_out}, 32'h3C);
    repeat (20) @(posedge clk);

    #1 loopback = 1'b0; rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("stuck_err_early", {31'b0, uio_out[5]}, 32'h0);
    check("stuck_valid_clr", {31'b0, uio_out[4]}, 32'h0);
    repeat (10) @(posedge clk);
    #2;
    check("stuck_error", {31'b0, uio_out[5]}, 32'h1);
    check("stuck_valid", {31'b0, uio_out[4]}, 32'h0);
    check("stuck_data_kept", {24'b0, uo_out}, 32'h3C);
    rx_drv = 1'b0;
    repeat (5) @(posedge clk);

    #1 loopback = 1'b1; ui_in = 8'h55; tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    repeat (70) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("abort_uo_out", {24'b0, uo_out}, 32'h00);
    check("abort_uio_out", {24'b0, uio_out}, 32'h00);
    @(posedge clk); #1 rst_n = 1'b0; ui_in = 8'h81; tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    wait_valid(waited);
    check("lb81_in_time", 32'(waited < 150), 32'h1);
    check("lb81_data", {24'b0, uo_out}, 32'h81);
    check("lb81_error", {31'b0, uio_out[5]}, 32'h0);
    repeat (20) @(posedge clk);

    #1 loopback = 1'b0; ui_in = 8'h5A; tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    watch_frame(50, busy_cnt, head, fbits);
    check("repulse_busy_len", busy_cnt, 144);
    check("repulse_frame_bits", {23'b0, fbits}, {23'b0, 9'h15A});

    valid_seen = 0;
    loopback = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      ena      = ($urandom_range(0, 7) != 0);
      tx_start = (i >= 3000 && i < 4000) ? 1'b1 : ($urandom_range(0, 19) == 0);
      ui_in    = 8'($urandom);
      if (uio_out[4]) valid_seen++;
    end
    check("rand_valid_seen", 32'(valid_seen > 0), 32'h1);

    tx_start = 1'b0;
    loopback = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 5) == 0) rx_drv = ~rx_drv;
      rst_n    = (i >= 1500 && i < 1503);
      tx_start = ($urandom_range(0, 49) == 0);
      ui_in    = 8'($urandom);
    end
    tx_start = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
